scsi_bus_arbiter: RTL and testbench



---
 rtl/scsi_pkg.sv | 17 +
 rtl/scsi_bus_arbiter_counter.sv | 23 ++
 rtl/scsi_bus_arbiter.sv | 98 +++++++++
 tb/tb_scsi_bus_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/scsi_pkg.sv
// Shared definitions for the NCR 53C710 Zorro III bus-master arbiter:
// the FSM state encoding and the default timing parameters.
package scsi_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'b000,
        ARB_REQ   = 3'b001,
        ARB_GRANT = 3'b010,
        ARB_OWN   = 3'b011,
        ARB_HOLD  = 3'b100
    } arb_state_t;

    localparam int ACK_TIMEOUT_DEFAULT = 15;
    localparam int HOLDOFF_DEFAULT     = 2;
    localparam int CNT_W_DEFAULT       = 4;

endpackage

// File: rtl/scsi_bus_arbiter_counter.sv
// Saturating up-counter with synchronous clear, shared by the grant-acknowledge
// timeout and the post-tenure hold-off.
module arb_counter #(
    parameter int CNT_W = 4
) (
    input  logic             bclk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state is written with <= only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge bclk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/scsi_bus_arbiter.sv
// Sequences NCR 53C710 bus-master tenures onto Zorro III: request, grant
// hand-off, ownership (mybus) and a hold-off before the next request.
module scsi_bus_arbiter
    import scsi_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT,
    parameter int HOLDOFF     = HOLDOFF_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic bclk,
    input  logic reset,
    input  logic SBR_n,
    input  logic SBGACK_n,
    input  logic BGRANT_n,
    input  logic bus_idle,
    input  logic scsi_cycle,
    output logic BREQ_n,
    output logic BGACK_n,
    output logic SBG_n,
    output logic mybus,
    output logic ack_timeout
);

    localparam logic [CNT_W-1:0] ACK_LIMIT = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    arb_state_t       state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr, cnt_en, timeout_evt;
    logic             breq_d, bgack_d, sbg_d, mybus_d;

    // Clearing on any state change gives every state a count starting at 0.
    assign cnt_clr = (next_state != state);
    assign cnt_en  = (state == ARB_GRANT) || (state == ARB_HOLD);

    arb_counter #(.CNT_W(CNT_W)) u_counter (
        .bclk  (bclk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt)
    );

    // NOTE: every always_comb output gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        next_state  = state;
        timeout_evt = 1'b0;
        case (state)
            ARB_IDLE:  if (!SBR_n && !scsi_cycle) next_state = ARB_REQ;
            ARB_REQ: begin
                if (SBR_n)
                    next_state = ARB_IDLE;
                else if (!BGRANT_n && bus_idle && !scsi_cycle)
                    next_state = ARB_GRANT;
            end
            ARB_GRANT: begin
                // An acknowledge on the timeout cycle still wins.
                if (!SBGACK_n) begin
                    next_state = ARB_OWN;
                end else if (cnt >= ACK_LIMIT) begin
                    next_state  = ARB_HOLD;
                    timeout_evt = 1'b1;
                end else if (SBR_n) begin
                    next_state = ARB_HOLD;
                end
            end
            ARB_OWN:   if (SBGACK_n) next_state = ARB_HOLD;
            ARB_HOLD:  if (cnt >= HOLD_LAST) next_state = ARB_IDLE;
            default:   next_state = ARB_IDLE;
        endcase

        // Outputs are decoded from the next state so they register on entry.
        breq_d  = !((next_state == ARB_REQ) || (next_state == ARB_GRANT));
        sbg_d   = (next_state != ARB_GRANT);
        bgack_d = (next_state != ARB_OWN);
        mybus_d = (next_state == ARB_OWN);
    end

    always_ff @(posedge bclk) begin
        if (reset) begin
            state       <= ARB_IDLE;
            BREQ_n      <= 1'b1;
            BGACK_n     <= 1'b1;
            SBG_n       <= 1'b1;
            mybus       <= 1'b0;
            ack_timeout <= 1'b0;
        end else begin
            state       <= next_state;
            BREQ_n      <= breq_d;
            BGACK_n     <= bgack_d;
            SBG_n       <= sbg_d;
            mybus       <= mybus_d;
            ack_timeout <= timeout_evt;
        end
    end

endmodule

// File: tb/tb_scsi_bus_arbiter.sv
// Self-checking bench for scsi_bus_arbiter: each driven cycle pushes the
// expected output vector {BREQ_n,BGACK_n,SBG_n,mybus,ack_timeout} to a queue.
module tb_scsi_bus_arbiter;

    logic bclk = 1'b0;
    logic reset, SBR_n, SBGACK_n, BGRANT_n, bus_idle, scsi_cycle;
    logic BREQ_n, BGACK_n, SBG_n, mybus, ack_timeout;

    int errors = 0;
    int checks = 0;

    // Expected output vectors: {BREQ_n, BGACK_n, SBG_n, mybus, ack_timeout}
    localparam logic [4:0] O_IDLE  = 5'b11100;
    localparam logic [4:0] O_REQ   = 5'b01100;
    localparam logic [4:0] O_GRANT = 5'b01000;
    localparam logic [4:0] O_OWN   = 5'b10110;
    localparam logic [4:0] O_HOLD  = 5'b11100;
    localparam logic [4:0] O_TO    = 5'b11101;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    scsi_bus_arbiter dut (
        .bclk        (bclk),
        .reset       (reset),
        .SBR_n       (SBR_n),
        .SBGACK_n    (SBGACK_n),
        .BGRANT_n    (BGRANT_n),
        .bus_idle    (bus_idle),
        .scsi_cycle  (scsi_cycle),
        .BREQ_n      (BREQ_n),
        .BGACK_n     (BGACK_n),
        .SBG_n       (SBG_n),
        .mybus       (mybus),
        .ack_timeout (ack_timeout)
    );

    always #5 bclk = ~bclk;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (BREQ_n,BGACK_n,SBG_n,mybus,ack_timeout)",
                     tag, got, exp);
        end
    endtask

    // Push what the outputs must be after the coming edge, clock once,
    // then pop and compare 1 ns after the edge.
    task automatic tick(input string tag, input logic [4:0] exp);
        sb_entry_t e;
        sb_q.push_back('{tag: tag, exp: exp});
        @(posedge bclk);
        #1;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, {BREQ_n, BGACK_n, SBG_n, mybus, ack_timeout}, e.exp);
        end
    endtask

    initial begin
        reset = 1'b1; SBR_n = 1'b1; SBGACK_n = 1'b1;
        BGRANT_n = 1'b0; bus_idle = 1'b1; scsi_cycle = 1'b0;
        tick("reset0", O_IDLE);
        tick("reset1", O_IDLE);
        reset = 1'b0;
        tick("idle", O_IDLE);

        // Normal tenure; SBR_n stays low through the hold-off to prove it is ignored.
        SBR_n = 1'b0;
        tick("norm_breq_t1", O_REQ);
        tick("norm_sbg_t2", O_GRANT);
        tick("norm_grant_t3", O_GRANT);
        tick("norm_grant_t4", O_GRANT);
        SBGACK_n = 1'b0;
        tick("norm_own_t5", O_OWN);
        for (int i = 6; i <= 20; i++) tick($sformatf("norm_own_t%0d", i), O_OWN);
        SBGACK_n = 1'b1;
        tick("norm_hold_t21", O_HOLD);
        tick("norm_hold_t22", O_HOLD);
        tick("norm_idle_t23", O_IDLE);
        tick("norm_rereq_t24", O_REQ);
        SBR_n = 1'b1;
        tick("norm_withdraw", O_IDLE);

        // Slave access has priority over a pending NCR request.
        SBR_n = 1'b0; scsi_cycle = 1'b1;
        for (int i = 0; i < 10; i++) tick($sformatf("slave_block%0d", i), O_IDLE);
        scsi_cycle = 1'b0;
        tick("slave_release_req", O_REQ);
        scsi_cycle = 1'b1;
        for (int i = 0; i < 3; i++) tick($sformatf("req_slave_hold%0d", i), O_REQ);
        scsi_cycle = 1'b0;
        tick("req_slave_grant", O_GRANT);
        SBR_n = 1'b1;
        tick("withdraw_hold0", O_HOLD);
        tick("withdraw_hold1", O_HOLD);
        tick("withdraw_idle", O_IDLE);

        // Busy bus: grant is present but the bus is not yet free.
        SBR_n = 1'b0; bus_idle = 1'b0;
        for (int i = 0; i < 6; i++) tick($sformatf("busy_req%0d", i), O_REQ);
        bus_idle = 1'b1;
        tick("busy_grant", O_GRANT);
        SBR_n = 1'b1;
        tick("busy_hold0", O_HOLD);
        tick("busy_hold1", O_HOLD);
        tick("busy_idle", O_IDLE);

        // Ack timeout: SBG_n held for counter values 0..15, then pulse and hold-off.
        SBR_n = 1'b0;
        tick("to_req", O_REQ);
        tick("to_grant_c0", O_GRANT);
        for (int i = 1; i <= 15; i++) tick($sformatf("to_grant_c%0d", i), O_GRANT);
        tick("to_pulse", O_TO);
        SBR_n = 1'b1;
        tick("to_hold_nopulse", O_HOLD);
        tick("to_idle", O_IDLE);

        // Timeout tie: acknowledge on the counter==15 cycle wins.
        SBR_n = 1'b0;
        tick("tie_req", O_REQ);
        tick("tie_grant_c0", O_GRANT);
        for (int i = 1; i <= 15; i++) tick($sformatf("tie_grant_c%0d", i), O_GRANT);
        SBGACK_n = 1'b0;
        tick("tie_own", O_OWN);
        BGRANT_n = 1'b1;
        tick("own_bgrant_ignored0", O_OWN);
        tick("own_bgrant_ignored1", O_OWN);

        // Reset mid-tenure.
        reset = 1'b1;
        tick("rst_own", O_IDLE);
        reset = 1'b0; SBGACK_n = 1'b1; SBR_n = 1'b1; BGRANT_n = 1'b0;
        tick("rst_after", O_IDLE);
        SBR_n = 1'b0;
        tick("rst_state_idle", O_REQ);
        BGRANT_n = 1'b1;
        tick("no_grant_wait", O_REQ);
        SBR_n = 1'b1;
        tick("final_idle", O_IDLE);

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
